// File: rtl/gpu_pkg.sv
// Shared GPU definitions: read-back FIFO sizing and the pixel-pair word type.
package gpu_pkg;

  localparam int GPU_RDFIFO_DEPTH_LOG2 = 4;

  // Two 16-bit pixels per word; bits 15:0 carry the first pixel.
  typedef logic [31:0] pixel_pair_t;

endpackage

// File: rtl/gpu_fifo_ram.sv
// Storage array for the VRAM->CPU read-back FIFO: synchronous write, asynchronous read.
module gpu_fifo_ram
  import gpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = GPU_RDFIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  pixel_pair_t           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output pixel_pair_t           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // No reset on the array; entries only become visible once written.
  pixel_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpu_vram2cpu_fifo.sv
// VRAM->CPU read-back FIFO feeding the GPUREAD latch.
// Optional underflow-read counter port enabled by macro GPU_RDFIFO_UNDERFLOW_CNT_EN.
module gpu_vram2cpu_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = GPU_RDFIFO_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_writeFIFO,
  input  logic [31:0]           i_pairPixel,
  output logic                  o_canPush,
  output logic                  o_empty,
  input  logic                  i_cpuRead,
  output logic [31:0]           o_gpuRead,
  input  logic                  i_flush,
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [15:0]           o_underflowCnt
`else
  output logic [DEPTH_LOG2:0]   o_level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL     = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_PUSH_MAX = (DEPTH_LOG2+1)'(DEPTH - 2);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE      = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE        = (DEPTH_LOG2)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  pixel_pair_t           gpu_read;
  pixel_pair_t           head;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ram_we;

  // Acceptance is judged on the pre-edge level, so a pop cannot make room for a same-cycle push.
  assign push_ok = i_writeFIFO && (level != LEVEL_FULL);
  assign pop_ok  = i_cpuRead && (level != '0);
  assign ram_we  = push_ok && !i_flush;

  gpu_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (i_clk),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(i_pairPixel),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        level <= level + LEVEL_ONE;
      end else if (pop_ok && !push_ok) begin
        level <= level - LEVEL_ONE;
      end
    end
  end

  // The latch survives a flush; it only changes on a real pop.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      gpu_read <= '0;
    end else if (pop_ok && !i_flush) begin
      gpu_read <= head;
    end
  end

`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
  localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;
  logic [15:0] underflow_cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      underflow_cnt <= '0;
    end else if (i_cpuRead && (level == '0) && (underflow_cnt != UNDERFLOW_MAX)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  assign o_underflowCnt = underflow_cnt;
`endif

  assign o_empty   = (level == '0);
  assign o_canPush = (level <= LEVEL_PUSH_MAX);
  assign o_level   = level;
  assign o_gpuRead = gpu_read;

endmodule

// File: tb/tb_gpu_vram2cpu_fifo.sv
// Self-checking bench for gpu_vram2cpu_fifo: vector table, directed corner cases and a
// randomized run against a queue-based reference model.
module tb_gpu_vram2cpu_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic              i_clk = 1'b0;
  logic              i_nrst = 1'b0;
  logic              i_writeFIFO = 1'b0;
  logic [31:0]       i_pairPixel = '0;
  logic              o_canPush;
  logic              o_empty;
  logic              i_cpuRead = 1'b0;
  logic [31:0]       o_gpuRead;
  logic              i_flush = 1'b0;
  logic [DEPTH_LOG2:0] o_level;
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
  logic [15:0]       o_underflowCnt;
`endif

  gpu_vram2cpu_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .i_writeFIFO   (i_writeFIFO),
    .i_pairPixel   (i_pairPixel),
    .o_canPush     (o_canPush),
    .o_empty       (o_empty),
    .i_cpuRead     (i_cpuRead),
    .o_gpuRead     (o_gpuRead),
    .i_flush       (i_flush),
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    .o_level       (o_level),
    .o_underflowCnt(o_underflowCnt)
`else
    .o_level       (o_level)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a queue, plus the GPUREAD latch and underflow count.
  logic [31:0] model_q [$];
  logic [31:0] model_latch = '0;
  int          model_cnt = 0;

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        read;
    logic        flush;
    int          exp_level;
    logic        exp_empty;
    logic        exp_can_push;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " level"}, 32'(o_level), 32'(model_q.size()));
    checkOutput({tag, " empty"}, 32'(o_empty), 32'(model_q.size() == 0));
    checkOutput({tag, " canPush"}, 32'(o_canPush), 32'(model_q.size() <= DEPTH - 2));
    checkOutput({tag, " gpuRead"}, o_gpuRead, model_latch);
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    checkOutput({tag, " underflowCnt"}, 32'(o_underflowCnt), 32'(model_cnt));
`endif
  endtask

  // Drives one cycle of strobes, advances the model at the edge, and samples 1 time unit later.
  task automatic applyStimulus(input logic push, input logic [31:0] data, input logic read, input logic flush);
    int pre;
    i_writeFIFO = push;
    i_pairPixel = data;
    i_cpuRead   = read;
    i_flush     = flush;
    @(posedge i_clk);
    pre = model_q.size();
    if (read && pre == 0 && model_cnt != 65535) model_cnt++;
    if (flush) begin
      model_q.delete();
    end else begin
      if (read && pre > 0) model_latch = model_q.pop_front();
      if (push && pre < DEPTH) model_q.push_back(data);
    end
    #1;
    i_writeFIFO = 1'b0;
    i_cpuRead   = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic doReset();
    i_nrst = 1'b0;
    model_q.delete();
    model_latch = '0;
    model_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
  endtask

  initial begin
    logic [31:0] saved;
    logic [31:0] val;

    vecs[0] = '{1'b1, 32'h11112222, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h00000000};
    vecs[1] = '{1'b1, 32'h33334444, 1'b0, 1'b0, 2, 1'b0, 1'b1, 32'h00000000};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 1, 1'b0, 1'b1, 32'h11112222};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 1'b1, 1'b1, 32'h33334444};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 1'b1, 1'b1, 32'h33334444};
    vecs[5] = '{1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1, 1'b0, 1'b1, 32'h33334444};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 1'b1, 1'b1, 32'hAAAA5555};
    vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b0, 0, 1'b1, 1'b1, 32'hAAAA5555};

    // Outputs must hold reset values while reset is asserted.
    #12;
    checkOutput("reset level", 32'(o_level), 32'd0);
    checkOutput("reset empty", 32'(o_empty), 32'd1);
    checkOutput("reset canPush", 32'(o_canPush), 32'd1);
    checkOutput("reset gpuRead", o_gpuRead, 32'h0);
    doReset();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].push, vecs[i].data, vecs[i].read, vecs[i].flush);
      checkOutput($sformatf("vec%0d level", i), 32'(o_level), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d empty", i), 32'(o_empty), 32'(vecs[i].exp_empty));
      checkOutput($sformatf("vec%0d canPush", i), 32'(o_canPush), 32'(vecs[i].exp_can_push));
      checkOutput($sformatf("vec%0d gpuRead", i), o_gpuRead, vecs[i].exp_read);
    end
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    checkOutput("vec underflowCnt", 32'(o_underflowCnt), 32'd2);
`endif

    // Underflow read leaves the latch alone.
    doReset();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("underflow pre latch", o_gpuRead, 32'hDEADBEEF);
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    checkOutput("underflow pre cnt", 32'(o_underflowCnt), 32'd0);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("underflow latch", o_gpuRead, 32'hDEADBEEF);
    checkOutput("underflow empty", 32'(o_empty), 32'd1);
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    checkOutput("underflow cnt", 32'(o_underflowCnt), 32'd1);
`endif

    // Fill past full: canPush falls at 15, the 17th push is dropped.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 32'hC0000000 + 32'(i), 1'b0, 1'b0);
      checkModel($sformatf("fill%0d", i));
      if (i == 13) checkOutput("fill14 canPush", 32'(o_canPush), 32'd1);
      if (i == 14) checkOutput("fill15 canPush", 32'(o_canPush), 32'd0);
    end
    checkOutput("full level", 32'(o_level), 32'd16);

    // Push and read at full: head popped, push dropped.
    applyStimulus(1'b1, 32'h77777777, 1'b1, 1'b0);
    checkOutput("full pushpop level", 32'(o_level), 32'd15);
    checkOutput("full pushpop gpuRead", o_gpuRead, 32'hC0000000);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("drain%0d gpuRead", k), o_gpuRead, 32'hC0000000 + 32'(k));
    end
    checkModel("drained");

    // Flush at level 5 together with a push.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h50000000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    saved = o_gpuRead;
    checkOutput("preflush level", 32'(o_level), 32'd5);
    checkOutput("preflush gpuRead", saved, 32'h50000000);
    applyStimulus(1'b1, 32'h99999999, 1'b0, 1'b1);
    checkOutput("flush level", 32'(o_level), 32'd0);
    checkOutput("flush empty", 32'(o_empty), 32'd1);
    checkOutput("flush gpuRead", o_gpuRead, 32'h50000000);
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("postflush gpuRead", o_gpuRead, 32'h12345678);
    checkModel("postflush");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 49) == 0);
      checkModel($sformatf("rand%0d", n));
    end

    // Push/pop pairs across pointer wrap, then an async reset mid-stream.
    doReset();
    for (int i = 0; i < 40; i++) begin
      val = 32'hB0000000 + 32'(i * 3);
      applyStimulus(1'b1, val, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("pair%0d gpuRead", i), o_gpuRead, val);
    end
    checkModel("pairs");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hE0000000 + 32'(i), 1'b0, 1'b0);
    #3;
    i_nrst = 1'b0;
    #1;
    checkOutput("async reset level", 32'(o_level), 32'd0);
    checkOutput("async reset empty", 32'(o_empty), 32'd1);
    checkOutput("async reset canPush", 32'(o_canPush), 32'd1);
    checkOutput("async reset gpuRead", o_gpuRead, 32'h0);
`ifdef GPU_RDFIFO_UNDERFLOW_CNT_EN
    checkOutput("async reset cnt", 32'(o_underflowCnt), 32'd0);
`endif
    model_q.delete();
    model_latch = '0;
    model_cnt = 0;
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    applyStimulus(1'b1, 32'hF00DF00D, 1'b0, 1'b0);
    checkOutput("post reset level", 32'(o_level), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post reset gpuRead", o_gpuRead, 32'hF00DF00D);
    checkModel("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
